// File: rtl/bpsk_pkg.sv
// Shared constants for the UART transmit arbiter: frame bit layout, idle word,
// source-tag byte, FSM state encoding and the parity helper.
package bpsk_pkg;

    localparam int FRAME_W          = 11;
    localparam int FRAME_START_BIT  = 0;
    localparam int FRAME_DATA_LSB   = 1;
    localparam int FRAME_DATA_MSB   = 8;
    localparam int FRAME_PARITY_BIT = 9;
    localparam int FRAME_STOP_BIT   = 10;

    localparam logic [FRAME_W-1:0] IDLE_WORD  = 11'h7FF;
    localparam logic [7:0]         SOURCE_TAG = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_NEXT = 2'd3
    } arb_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_framer.sv
// Combinational UART framer: start bit, 8 data bits LSB-first, even parity, stop bit.
module uart_framer
    import bpsk_pkg::*;
(
    input  logic [7:0]         data_i,
    output logic [FRAME_W-1:0] word_o
);

    // Build the frame field by field on top of the idle pattern
    always_comb begin
        word_o                                = IDLE_WORD;
        word_o[FRAME_START_BIT]               = 1'b0;
        word_o[FRAME_DATA_MSB:FRAME_DATA_LSB] = data_i;
        word_o[FRAME_PARITY_BIT]              = even_parity(data_i);
        word_o[FRAME_STOP_BIT]                = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter feeding a UART serializer one framed byte at a time.
// Optional macro UART_ARB_SOURCE_TAG_EN prepends a header byte (8'hA0 | grant_id) to each packet.
module uart_tx_arbiter
    import bpsk_pkg::*;
#(
    parameter int PACKET_SIZE = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    input  logic [PACKET_SIZE-1:0] req0_packet,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [PACKET_SIZE-1:0] req1_packet,
    output logic                   req1_ready,
    output logic [FRAME_W-1:0]     uart_word,
    output logic                   word_valid,
    input  logic                   word_ack,
    output logic                   busy,
    output logic                   grant_id
);

    localparam int               NUM_BYTES = PACKET_SIZE / 8;
    localparam int               CNT_W     = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_BYTES);

    arb_state_e             state_q, state_d;
    logic [PACKET_SIZE-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   prio_q, prio_d;
    logic                   grant_q, grant_d;
    logic [FRAME_W-1:0]     word_q, word_d;
    logic                   valid_q;
    logic                   busy_q;
    logic                   armed_q;
    logic                   winner_s;
    logic                   ready0_s, ready1_s;
    logic [7:0]             byte_s;
    logic [FRAME_W-1:0]     frame_s;
`ifdef UART_ARB_SOURCE_TAG_EN
    logic                   hdr_q, hdr_d;
`endif

    // Byte presented to the framer: header first when tagging, then the packet MSB byte
    always_comb begin
`ifdef UART_ARB_SOURCE_TAG_EN
        if (hdr_q) begin
            byte_s = SOURCE_TAG | {7'd0, grant_q};
        end else begin
            byte_s = pkt_q[PACKET_SIZE-1 -: 8];
        end
`else
        byte_s = pkt_q[PACKET_SIZE-1 -: 8];
`endif
    end

    uart_framer u_framer (
        .data_i (byte_s),
        .word_o (frame_s)
    );

    // FSM next-state, arbitration and datapath update
    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        grant_d  = grant_q;
        word_d   = word_q;
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        winner_s = (req0_valid && req1_valid) ? prio_q : req1_valid;
`ifdef UART_ARB_SOURCE_TAG_EN
        hdr_d    = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // armed_q keeps ready low until the first edge after reset release
                if (armed_q && (req0_valid || req1_valid)) begin
                    state_d  = ST_LOAD;
                    grant_d  = winner_s;
                    prio_d   = ~winner_s;
                    cnt_d    = {CNT_W{1'b0}};
                    ready0_s = ~winner_s;
                    ready1_s = winner_s;
                    pkt_d    = winner_s ? req1_packet : req0_packet;
`ifdef UART_ARB_SOURCE_TAG_EN
                    hdr_d    = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
                word_d  = frame_s;
            end
            ST_SEND: begin
                if (word_ack) begin
                    state_d = ST_NEXT;
`ifdef UART_ARB_SOURCE_TAG_EN
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        pkt_d = pkt_q << 4'd8;
                    end
`else
                    cnt_d = cnt_q + CNT_W'(1);
                    pkt_d = pkt_q << 4'd8;
`endif
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_NEXT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any packet in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pkt_q   <= {PACKET_SIZE{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            word_q  <= IDLE_WORD;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
`ifdef UART_ARB_SOURCE_TAG_EN
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            word_q  <= word_d;
            valid_q <= (state_d == ST_SEND);
            busy_q  <= (state_d != ST_IDLE);
            armed_q <= 1'b1;
`ifdef UART_ARB_SOURCE_TAG_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign uart_word  = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 32, packet width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, the source holds its packet available.
REQ-005 SHALL have ports req0_packet / req1_packet, input, PACKET_SIZE each, packet data; the MSB byte is sent first.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each, a one-cycle pulse accepting that source's packet.
REQ-007 SHALL have port uart_word, output, 11, the framed word for the serializer.
REQ-008 SHALL have port word_valid, output, 1, meaning uart_word is valid and held.
REQ-009 SHALL have port word_ack, input, 1, a serializer pulse meaning the word was consumed.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port grant_id, output, 1, the source currently being sent; holds its last value when idle.

Function
REQ-012 SHALL implement states IDLE, LOAD, SEND, NEXT.
- IDLE -> LOAD when any req*_valid is high.
- LOAD -> SEND after one cycle.
- SEND -> NEXT on word_ack.
- NEXT -> LOAD if bytes remain, else IDLE.
REQ-013 SHALL arbitrate round-robin in IDLE.
- With a single requester, that requester wins.
- With both requesting, the winner is the source not granted last; after reset, source 0 has priority.
REQ-014 SHALL pulse the winner's req*_ready in the IDLE->LOAD cycle and capture its packet into an internal register in that same cycle.
- Source inputs are ignored until the FSM returns to IDLE.
REQ-015 SHALL frame each byte d[7:0] as follows.
- uart_word[0] = 0 (start bit).
- uart_word[8:1] = d.
- uart_word[9] = even parity (XOR of d).
- uart_word[10] = 1 (stop bit).
REQ-016 SHALL assert word_valid throughout SEND only; uart_word SHALL stay stable while word_valid is high.
REQ-017 SHALL ignore word_ack outside SEND.
- A word_ack in the same cycle word_valid first rises SHALL be accepted.
REQ-018 SHALL count bytes with a counter of width clog2(PACKET_SIZE/8)+1 and send exactly PACKET_SIZE/8 words per packet.
- Packet latency from accept to first word_valid is 2 cycles.
REQ-019 SHALL allow no new grant until the final NEXT->IDLE transition.
- A request held across that transition SHALL be granted on the cycle after IDLE is entered.
REQ-020 SHALL treat a request that drops before grant as never made; no ready pulse is issued for it.

Reset
REQ-021 SHALL, while reset_n is low, force:
- state IDLE, word_valid 0, req0_ready 0, req1_ready 0, busy 0, grant_id 0;
- uart_word 11'h7FF (line idle);
- byte counter 0, round-robin pointer to source 0.
REQ-022 SHALL on reset mid-packet discard the remaining bytes; the packet is not resent.

Configuration
REQ-023 SHALL support macro UART_ARB_SOURCE_TAG_EN.
- When defined: before the packet bytes, send one header byte 8'hA0|grant_id framed per REQ-015, so each packet is PACKET_SIZE/8+1 words.
- When undefined: no header is sent and the header logic is absent.

Structure
REQ-024 SHALL place the frame bit positions, the idle word 11'h7FF, the tag constant 8'hA0 and the state encoding in shared package bpsk_pkg.
REQ-025 SHALL implement framing as sub-module uart_framer (byte in, 11-bit word out, combinational); the arbiter instantiates it once.

Verification
REQ-026 Single request: req0_packet=32'h12345678 with ack 3 cycles after each word_valid -> words carry data 12, 34, 56, 78 with parity bits 0, 1, 0, 0 and stop bit 1; busy falls after the 4th ack.
REQ-027 Contention: both sources valid from reset -> grant order 0, 1, 0, 1 over four packets; exactly one ready pulse per accepted packet.
REQ-028 Ack-on-rise: word_ack high in the first word_valid cycle of every word -> all 4 words are accepted; total transfer takes 4 + 3×2 cycles after LOAD.
REQ-029 Reset mid-packet: assert reset_n=0 after the 2nd ack -> outputs match REQ-021 in the same cycle; the next packet starts with its MSB byte.
REQ-030 With UART_ARB_SOURCE_TAG_EN defined and source 1 granted -> the first word carries data A1 with parity bit 1, followed by 4 data words.
REQ-031 Stray ack: word_ack pulses in IDLE -> no state change and no output change.
